ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have these ports: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 The block SHALL have these ports: rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-003 The block SHALL have these ports: signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-004 The block SHALL have these ports: opdata1_i  in  32  dividend, from the ID/EX register.
REQ-005 The block SHALL have these ports: opdata2_i  in  32  divisor, from the ID/EX register.
REQ-006 The block SHALL have these ports: start_i  in  1  request from EX; held high until ready_o is seen.
REQ-007 The block SHALL have these ports: annul_i  in  1  cancel in-flight division (flush).
REQ-008 The block SHALL have these ports: result_o  out  64  {remainder[63:32], quotient[31:0]}.
REQ-009 The block SHALL have these ports: ready_o  out  1  result valid.
REQ-010 The block SHALL have these ports: stallreq_o  out  1  stall request to the pipeline controller; EX stage index.

Function
REQ-011 The block SHALL implement states FREE, BYZERO, ON, END in a 2-bit registered state machine.
REQ-012 In FREE, start_i=1 and annul_i=0 SHALL capture the operands and then go to BYZERO if opdata2_i==0, else ON; in all other cases the block SHALL stay in FREE.
REQ-013 On the FREE->ON transition, the block SHALL load a 65-bit work register with {32'b0, |dividend|, 1'b0} and clear a 6-bit counter.
REQ-014 Each ON cycle SHALL perform one restoring step: trial = work[64:32] - {1'b0,|divisor|}.
REQ-015 If the trial is non-negative, work SHALL become {trial[31:0], work[31:0], 1'b1}; otherwise it SHALL shift left by 1 with bit 0 = 0.
REQ-016 The counter SHALL increment once per ON cycle; after exactly 32 steps (counter==32) the block SHALL go to END.
REQ-017 On entering END, quotient SHALL = work[31:0] and remainder SHALL = work[64:33], both sign-corrected per REQ-024.
REQ-018 BYZERO SHALL go to END in one cycle with result = 64'h0.
REQ-019 In END, ready_o SHALL = 1 and result_o SHALL hold the result; when start_i==0 the block SHALL go to FREE, clear ready_o, and set result_o = 0.
REQ-020 Latency (sampled start to first ready_o): 34 cycles for a nonzero divisor; 2 cycles for a zero divisor.
REQ-021 stallreq_o SHALL equal start_i & ~ready_o (combinational), so the pipeline stalls until the result is available.
REQ-022 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, ready_o=0, and no result; annul_i in END SHALL be ignored.
REQ-023 Operands SHALL be registered at start; input changes during ON SHALL have no effect.
REQ-024 Sign correction: quotient SHALL be negated when the dividend sign differs from the divisor sign; the remainder SHALL take the sign of the dividend; all arithmetic SHALL be mod 2^32.
REQ-025 For 0x80000000 / 0xFFFFFFFF signed, the block SHALL return quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-026 If start_i is held high in END, the block SHALL remain in END with ready_o=1; it SHALL NOT restart.

Reset
REQ-027 When rst==0 at a clock edge, the block SHALL set state = FREE, result_o = 64'h0, ready_o = 0, counter = 0, and work = 0; reset during ON SHALL abandon the operation.
REQ-028 Reset SHALL take priority over start_i and annul_i.

Configuration
REQ-029 With macro DIV_SIGNED_EN defined, signed_div_i SHALL select signed operation per REQ-024.
REQ-030 Without DIV_SIGNED_EN, signed_div_i SHALL be ignored, all divisions SHALL be unsigned, and no negation logic SHALL be generated.

Verification
REQ-031 The bench SHALL cover: unsigned 100/7, start held -> ready_o at cycle 34, result_o = {32'd2, 32'd14}; start dropped -> FREE, result_o = 0.
REQ-032 The bench SHALL cover: signed -7/2 (DIV_SIGNED_EN) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-033 The bench SHALL cover: divisor 0, dividend 0x1234 -> ready_o after 2 cycles, result_o = 64'h0.
REQ-034 The bench SHALL cover: annul_i pulsed at ON step 10 -> FREE next cycle, ready_o never asserts; a new start of 9/3 then gives {0, 3}.
REQ-035 The bench SHALL cover: rst=0 at ON step 20 -> all outputs 0 next cycle; a subsequent 0xFFFFFFFF/1 unsigned gives quotient 0xFFFFFFFF, remainder 0.
REQ-036 The bench SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; without DIV_SIGNED_EN, the same operands give quotient 0, remainder 0x80000000.

Source files
------------

// File: rtl/ex_div.sv
// rtl/ex_div.sv - 32-bit iterative restoring divider for the EX stage (optional DIV_SIGNED_EN)
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'b00,
    S_BYZERO = 2'b01,
    S_ON     = 2'b10,
    S_END    = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic [64:0] work;
  logic [5:0]  cnt;
  logic [31:0] divisor_abs;
  logic [63:0] result_q;
  logic [32:0] trial;
  logic [31:0] dividend_abs_in;
  logic [31:0] divisor_abs_in;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        accept;

  assign accept = start_i & ~annul_i;

`ifdef DIV_SIGNED_EN
  logic dvd_neg_in;
  logic dvs_neg_in;
  logic neg_quot;
  logic neg_rem;

  assign dvd_neg_in      = signed_div_i & opdata1_i[31];
  assign dvs_neg_in      = signed_div_i & opdata2_i[31];
  assign dividend_abs_in = dvd_neg_in ? (~opdata1_i + 32'd1) : opdata1_i;
  assign divisor_abs_in  = dvs_neg_in ? (~opdata2_i + 32'd1) : opdata2_i;
  assign quot_fix        = neg_quot ? (~work[31:0] + 32'd1) : work[31:0];
  assign rem_fix         = neg_rem ? (~work[64:33] + 32'd1) : work[64:33];

  // Sign flags are captured with the operands so later input changes cannot disturb correction
  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (state == S_FREE && accept) begin
      neg_quot <= dvd_neg_in ^ dvs_neg_in;
      neg_rem  <= dvd_neg_in;
    end
  end
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign dividend_abs_in   = opdata1_i;
  assign divisor_abs_in    = opdata2_i;
  assign quot_fix          = work[31:0];
  assign rem_fix           = work[64:33];
`endif

  // Trial subtraction of the divisor from the partial remainder; bit 32 set means it went negative
  assign trial = work[64:32] - {1'b0, divisor_abs};

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_FREE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FREE: begin
        if (accept) state_nxt = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: begin
        state_nxt = annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        if (annul_i)            state_nxt = S_FREE;
        else if (cnt == 6'd32)  state_nxt = S_END;
      end
      S_END: begin
        if (!start_i) state_nxt = S_FREE;
      end
      default: state_nxt = S_FREE;
    endcase
  end

  // Datapath: operand capture, one restoring step per ON cycle, result latch on completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      work        <= 65'd0;
      cnt         <= 6'd0;
      divisor_abs <= 32'd0;
      result_q    <= 64'd0;
    end else begin
      case (state)
        S_FREE: begin
          if (accept) begin
            work        <= {32'd0, dividend_abs_in, 1'b0};
            divisor_abs <= divisor_abs_in;
            cnt         <= 6'd0;
            result_q    <= 64'd0;
          end
        end
        S_BYZERO: begin
          result_q <= 64'd0;
        end
        S_ON: begin
          if (!annul_i) begin
            if (cnt != 6'd32) begin
              if (!trial[32]) work <= {trial[31:0], work[31:0], 1'b1};
              else            work <= {work[63:0], 1'b0};
              cnt <= cnt + 6'd1;
            end else begin
              result_q <= {rem_fix, quot_fix};
            end
          end
        end
        S_END: begin
          if (!start_i) result_q <= 64'd0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: result is only presented while in END
  always_comb begin
    ready_o    = (state == S_END);
    result_o   = (state == S_END) ? result_q : 64'd0;
    stallreq_o = start_i & ~ready_o;
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - randomized self-checking bench for ex_div against an arithmetic reference
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks;
  int failures;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic   signed_mode;
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
`ifdef DIV_SIGNED_EN
    signed_mode = sgn;
`else
    signed_mode = 1'b0;
`endif
    if (b == 32'd0) return 64'd0;
    if (signed_mode) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input int hold);
    logic [63:0] exp;
    int exp_lat;
    int n;
    exp     = model(a, b, sgn);
    exp_lat = (b == 32'd0) ? 2 : 34;
    n       = 0;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    #1;
    check({tag, ":stall_busy"}, {63'd0, stallreq}, 64'd1);
    do begin
      @(negedge clk);
      n++;
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = 1'($urandom);
    end while (!ready && n < 100);
    check({tag, ":latency"}, 64'(n), 64'(exp_lat));
    check({tag, ":result"}, result, exp);
    check({tag, ":stall_done"}, {63'd0, stallreq}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      annul = 1'b1;
      @(negedge clk);
      check({tag, ":hold_ready"}, {63'd0, ready}, 64'd1);
      check({tag, ":hold_result"}, result, exp);
    end
    annul = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check({tag, ":free_ready"}, {63'd0, ready}, 64'd0);
    check({tag, ":free_result"}, result, 64'd0);
  endtask

  initial begin
    int seen_ready;
    logic [31:0] ra, rb;
    logic        rs;
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", {63'd0, stallreq}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 3);
    check("u100_7_const", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_div("zero_div", 32'h0000_1234, 32'd0, 1'b0, 1);

    // Flush in the middle of the iteration
    opdata1 = 32'd50;
    opdata2 = 32'd3;
    start   = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    check("annul_ready", {63'd0, ready}, 64'd0);
    check("annul_result", result, 64'd0);
    seen_ready = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen_ready++;
    end
    check("annul_no_ready", 64'(seen_ready), 64'd0);
    run_div("u9_3", 32'd9, 32'd3, 1'b0, 0);

    // Reset in the middle of the iteration
    opdata1 = 32'd1000;
    opdata2 = 32'd7;
    start   = 1'b1;
    repeat (20) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_stall", {63'd0, stallreq}, 64'd0);
    rst = 1'b1;
    run_div("uffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);

    run_div("s_min_-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div("u_min_-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = ~32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom);
      run_div($sformatf("rand%0d", k), ra, rb, rs, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
